// File: rtl/gpr_dump_reader.sv
// gpr_dump_reader
// Read-side master for the GPR file. It walks a range of register indices on the
// rs read port and streams each captured word out over a valid/ready interface.
// The dump never touches the write port, so the CPU keeps running during a dump.
//
// Output handshake: out_valid/out_data/out_idx are registered. Once out_valid
// rises, out_data and out_idx hold until the cycle where out_valid && out_ready.
// That cycle transfers the word. out_valid never drops without a transfer,
// except on abort or reset.

module gpr_dump_reader #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] last_q;
  logic [AW-1:0] next_addr;
  logic          handshake;
  logic          at_last;

  // The index wraps from NREG-1 back to 0, so a range with last < first
  // continues through the top of the file.
  always_comb begin
    next_addr = rd_addr + 1'b1;
    if (rd_addr == AW'(NREG - 1)) begin
      next_addr = '0;
    end
  end

  // Decode the transfer and end-of-range conditions used by the FSM.
  always_comb begin
    handshake = out_valid && out_ready;
    at_last   = (out_idx == last_q);
  end

  // Expose the current state for debug and for binding checkers.
  always_comb begin
    dbg_state = state;
  end

  // Dump FSM. Every output is a register. done is a single-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_addr   <= '0;
      last_q    <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // abort held together with start cancels the request before it begins.
          if (start && !abort) begin
            last_q  <= last_idx;
            rd_addr <= first_idx;
            busy    <= 1'b1;
            state   <= ST_READ;
          end
        end

        ST_READ: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            // busA has had a full cycle to settle on rd_addr. A GPR write on
            // this same edge is not visible yet, so the pre-write value is taken.
            out_data  <= rd_data;
            out_idx   <= rd_addr;
            out_valid <= 1'b1;
            state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (abort) begin
            // abort outranks a transfer offered on the same edge.
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (handshake) begin
            out_valid <= 1'b0;
            if (at_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              rd_addr <= next_addr;
              state   <= ST_READ;
            end
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_dump_reader.sv
// tb_gpr_dump_reader
// Scoreboard bench for gpr_dump_reader. A behavioural GPR file drives rd_data.
// Each dump request pushes its expected (idx, data) words. A monitor pops and
// compares them on every accepted transfer.

module tb_gpr_dump_reader;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int W    = AW + DW;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_idx;
  logic [AW-1:0] last_idx;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  // Behavioural GPR file. Writes land on the clock edge. Register 0 reads 0.
  logic [DW-1:0] gpr [NREG];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  // Scoreboard state.
  logic [W-1:0]  exp_q[$];
  int            n_checks;
  int            n_fail;
  int            cyc;
  int            hs_cnt;
  int            done_cnt;
  int            last_done_cyc;
  int            word_n;
  int            t0;
  logic          time_chk;
  int            ready_mode;

  gpr_dump_reader #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- GPR model ----------------
  always @(posedge clk) begin
    if (wr_en && wr_addr != '0) gpr[wr_addr] <= wr_data;
  end
  assign rd_data = (rd_addr == '0) ? '0 : gpr[rd_addr];

  // Sink readiness: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_pending;
  logic [W-1:0]  held;
  logic [W-1:0]  exp_w;

  initial begin
    hold_pending = 1'b0;
    held = '0;
  end

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (hold_pending) check("hold_stable", {out_idx, out_data}, held);
      if (out_ready) begin
        hold_pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {out_idx, out_data}, '1);
        end else begin
          exp_w = exp_q.pop_front();
          check("word_idx",  out_idx,  exp_w[W-1:DW]);
          check("word_data", out_data, exp_w[DW-1:0]);
        end
        if (time_chk) check("accept_edge", cyc + 1, t0 + 2 + 2 * word_n);
        word_n++;
        hs_cnt++;
      end else begin
        hold_pending = 1'b1;
        held = {out_idx, out_data};
      end
    end else begin
      hold_pending = 1'b0;
    end
    if (!reset && done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Push the expected words for the range, then issue a one-cycle start.
  // k returns the number of the clock edge that samples start.
  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, output int k);
    int n;
    logic [AW-1:0] idx;
    logic [DW-1:0] d;
    n = ((int'(l) - int'(f) + NREG) % NREG) + 1;
    for (int i = 0; i < n; i++) begin
      idx = AW'((int'(f) + i) % NREG);
      d = (idx == '0) ? '0 : gpr[idx];
      exp_q.push_back({idx, d});
    end
    start = 1'b1;
    first_idx = f;
    last_idx = l;
    k = cyc + 1;
    word_n = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_cnt != d0) break;
    end
    tick();
    tick();
    check("done_pulses", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic wait_hs(input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (hs_cnt >= target) break;
      tick();
    end
    check("hs_reached", hs_cnt >= target, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int d0;
    int f;
    int l;
    n_checks = 0; n_fail = 0; cyc = 0; hs_cnt = 0; done_cnt = 0;
    last_done_cyc = 0; word_n = 0; t0 = 0; time_chk = 1'b0; ready_mode = 1;
    reset = 1'b1; start = 1'b0; abort = 1'b0; first_idx = '0; last_idx = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) gpr[i] = '0;

    // Reset values.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_state", dbg_state, 0);
    tick();
    reset = 1'b0;
    tick();

    // Full dump with the expected accept timing.
    for (int i = 1; i < NREG; i++) write_reg(AW'(i), DW'(i) * 32'h11111111);
    write_reg(0, 32'hFFFFFFFF);
    ready_mode = 1;
    tick();
    time_chk = 1'b1;
    start_dump(0, 31, k);
    t0 = k;
    check("busy_after_start", busy, 1);
    wait_done(200);
    time_chk = 1'b0;
    check("done_edge", last_done_cyc, k + 64);

    // Backpressure on a single-word dump.
    write_reg(5, 32'hDEADBEEF);
    ready_mode = 0;
    tick();
    d0 = hs_cnt;
    start_dump(5, 5, k);
    for (int i = 0; i < 10; i++) tick();
    check("bp_valid_held", out_valid, 1);
    check("bp_data_held", out_data, 32'hDEADBEEF);
    ready_mode = 1;
    wait_done(50);
    check("bp_single_hs", hs_cnt - d0, 1);

    // Wrap through NREG-1 to 0, with a random sink.
    ready_mode = 2;
    start_dump(30, 1, k);
    wait_done(200);

    // Abort after the third accepted word: no done pulse.
    ready_mode = 1;
    d0 = hs_cnt;
    start_dump(0, 15, k);
    wait_hs(d0 + 3, 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_done", done_cnt - d0, 0);

    // start and abort together while idle: stays idle.
    start = 1'b1; abort = 1'b1; first_idx = 3; last_idx = 4;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    check("start_abort_idle", busy, 0);

    // start while busy is ignored.
    start_dump(0, 5, k);
    tick(); tick(); tick();
    start = 1'b1; first_idx = 7; last_idx = 9;
    tick();
    start = 1'b0;
    wait_done(100);

    // A GPR write on the capture edge: the pre-write value is captured.
    write_reg(9, 32'hAAAA5555);
    start_dump(9, 9, k);
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    wait_done(50);
    start_dump(9, 9, k);
    wait_done(50);

    // Reset mid-dump at word 10, then a fresh short dump.
    d0 = hs_cnt;
    start_dump(0, 31, k);
    wait_hs(d0 + 10, 100);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_state", dbg_state, 0);
    exp_q.delete();
    tick(); tick();
    #1 reset = 1'b0;
    tick();
    d0 = hs_cnt;
    start_dump(2, 3, k);
    wait_done(50);
    check("post_rst_words", hs_cnt - d0, 2);

    // Random ranges and contents with a random sink.
    for (int t = 0; t < 15; t++) begin
      for (int j = 0; j < 4; j++) write_reg(AW'($urandom_range(0, NREG - 1)), $urandom);
      ready_mode = 2;
      f = $urandom_range(0, NREG - 1);
      l = $urandom_range(0, NREG - 1);
      start_dump(AW'(f), AW'(l), k);
      wait_done(600);
      ready_mode = 1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
